// File: rtl/cpu_paddle_ai_pkg.sv
// -----------------------------------------------------------------------------
// cpu_paddle_ai_pkg
// Shared Pong definitions for the CPU paddle opponent:
//   - ai_state_e : AI state encodings (HOME=0, WAIT=1, TRACK=2)
//   - default playfield geometry (Y_W, SCREEN_H, PADDLE_H, HOME_Y)
//   - clamp_s    : signed clamp helper
//   - step_size  : per-frame step for a difficulty level, never below 1
// Optional build macro used by the top: CPU_PADDLE_JITTER_EN.
// -----------------------------------------------------------------------------
package cpu_paddle_ai_pkg;

  typedef enum logic [1:0] {
    ST_HOME  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TRACK = 2'd2
  } ai_state_e;

  localparam int Y_W_DEF      = 10;
  localparam int SCREEN_H_DEF = 480;
  localparam int PADDLE_H_DEF = 64;
  localparam int HOME_Y_DEF   = (SCREEN_H_DEF - PADDLE_H_DEF) / 2;

  function automatic int clamp_s(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Difficulty 0..3 scales MAX_STEP by 1/4..4/4; a step of 0 would stall the paddle.
  function automatic int step_size(input int max_step, input logic [1:0] difficulty);
    int s;
    s = (max_step * (int'(difficulty) + 1)) >>> 2;
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/cpu_paddle_ai_if.sv
// -----------------------------------------------------------------------------
// cpu_paddle_ai_if
// Groups the CPU paddle's frame-rate inputs and paddle outputs.
//   frame_tick  one-cycle pulse per video frame
//   enable      low freezes the AI
//   ball_y      ball top coordinate (Y_W)
//   ball_dir    1 = ball approaching the CPU side
//   difficulty  0..3 speed level
//   paddle_y    paddle top coordinate (Y_W, registered)
//   moving      paddle moved on the last frame_tick
//   ai_state    HOME=0, WAIT=1, TRACK=2
// Modports: master drives the inputs (game datapath / bench), slave is the AI.
// -----------------------------------------------------------------------------
interface cpu_paddle_ai_if #(
  parameter int Y_W = 10
);
  logic           frame_tick;
  logic           enable;
  logic [Y_W-1:0] ball_y;
  logic           ball_dir;
  logic [1:0]     difficulty;
  logic [Y_W-1:0] paddle_y;
  logic           moving;
  logic [1:0]     ai_state;

  modport master (
    output frame_tick, enable, ball_y, ball_dir, difficulty,
    input  paddle_y, moving, ai_state
  );

  modport slave (
    input  frame_tick, enable, ball_y, ball_dir, difficulty,
    output paddle_y, moving, ai_state
  );
endinterface

// File: rtl/cpu_paddle_stepper.sv
// -----------------------------------------------------------------------------
// cpu_paddle_stepper
// Combinational datapath: picks the target for the current AI state, then
// moves the paddle toward it by at most one difficulty-scaled step, without
// overshoot, honouring the dead zone and the playfield limits.
//   state       current (pre-transition) AI state
//   ball_y      ball top coordinate
//   paddle_y    current paddle top
//   difficulty  0..3 speed level
//   offset      signed target offset (jitter), 0 when unused
//   next_y      paddle top after this frame
//   moving      1 when next_y differs from paddle_y
// -----------------------------------------------------------------------------
module cpu_paddle_stepper
  import cpu_paddle_ai_pkg::*;
#(
  parameter int Y_W      = Y_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int PADDLE_H = PADDLE_H_DEF,
  parameter int HOME_Y   = HOME_Y_DEF,
  parameter int MAX_STEP = 8,
  parameter int DEADZONE = 2
) (
  input  ai_state_e             state,
  input  logic [Y_W-1:0]        ball_y,
  input  logic [Y_W-1:0]        paddle_y,
  input  logic [1:0]            difficulty,
  input  logic signed [Y_W+1:0] offset,
  output logic [Y_W-1:0]        next_y,
  output logic                  moving
);
  localparam int CW    = Y_W + 2;
  localparam int Y_MAX = SCREEN_H - PADDLE_H;

  typedef logic signed [CW-1:0] sw_t;

  sw_t py_s, by_s, raw, tgt, err, abs_err, step, mag, nxt;

  // Two guard bits keep ball_y - PADDLE_H/2 from wrapping near the top edge.
  assign py_s = $signed({2'b00, paddle_y});
  assign by_s = $signed({2'b00, ball_y});

  always_comb begin
    step    = sw_t'(step_size(MAX_STEP, difficulty));
    raw     = '0;
    tgt     = py_s;
    case (state)
      ST_HOME:  tgt = sw_t'(HOME_Y);
      ST_TRACK: begin
        raw = by_s - sw_t'(PADDLE_H / 2) + offset;
        tgt = sw_t'(clamp_s(int'(raw), 0, Y_MAX));
      end
      default:  tgt = py_s;
    endcase

    err     = tgt - py_s;
    abs_err = err[CW-1] ? -err : err;
    mag     = (abs_err < step) ? abs_err : step;

    nxt    = py_s;
    moving = 1'b0;
    if (abs_err > sw_t'(DEADZONE)) begin
      moving = 1'b1;
      nxt    = err[CW-1] ? (py_s - mag) : (py_s + mag);
      nxt    = sw_t'(clamp_s(int'(nxt), 0, Y_MAX));
    end
    next_y = nxt[Y_W-1:0];
  end

endmodule

// File: rtl/cpu_paddle_ai.sv
// -----------------------------------------------------------------------------
// cpu_paddle_ai
// Frame-rate, speed-limited computer opponent. A three-state AI returns the
// paddle home while the ball recedes, waits REACT_FRAMES ticks after the ball
// turns toward the CPU, then chases it.
//   clk, rst    clock; synchronous active-high reset
//   bus         cpu_paddle_ai_if.slave: frame_tick, enable, ball_y, ball_dir,
//               difficulty in; paddle_y, moving, ai_state out
// Build option: define CPU_PADDLE_JITTER_EN to add an LFSR-driven target
// offset (-16..15) latched on each WAIT->TRACK entry.
//
// state | meaning
// HOME  | ball receding; paddle returns to HOME_Y
// WAIT  | ball approaching; reaction delay, paddle holds
// TRACK | chasing the clamped ball-centred target
// -----------------------------------------------------------------------------
module cpu_paddle_ai
  import cpu_paddle_ai_pkg::*;
#(
  parameter int Y_W          = Y_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int HOME_Y       = HOME_Y_DEF,
  parameter int MAX_STEP     = 8,
  parameter int DEADZONE     = 2,
  parameter int REACT_FRAMES = 4
) (
  input logic            clk,
  input logic            rst,
  cpu_paddle_ai_if.slave bus
);
  localparam int CW    = Y_W + 2;
  localparam int CNT_W = $clog2(REACT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REACT_FRAMES - 1);

  ai_state_e             state;
  logic [CNT_W-1:0]      react_cnt;
  logic [Y_W-1:0]        paddle_q;
  logic                  moving_q;
  logic [Y_W-1:0]        next_y;
  logic                  step_moving;
  logic signed [CW-1:0]  offset;
  logic                  tick_en;
  logic                  enter_track;

  assign tick_en     = bus.frame_tick & bus.enable;
  assign enter_track = tick_en & bus.ball_dir & (state == ST_WAIT) & (react_cnt == CNT_LAST);

  // Stepper sees the pre-transition state, so the tick that enters TRACK
  // still behaves as WAIT.
  cpu_paddle_stepper #(
    .Y_W      (Y_W),
    .SCREEN_H (SCREEN_H),
    .PADDLE_H (PADDLE_H),
    .HOME_Y   (HOME_Y),
    .MAX_STEP (MAX_STEP),
    .DEADZONE (DEADZONE)
  ) u_stepper (
    .state      (state),
    .ball_y     (bus.ball_y),
    .paddle_y   (paddle_q),
    .difficulty (bus.difficulty),
    .offset     (offset),
    .next_y     (next_y),
    .moving     (step_moving)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOME;
      react_cnt <= '0;
      paddle_q  <= Y_W'(HOME_Y);
      moving_q  <= 1'b0;
    end else if (bus.frame_tick) begin
      if (bus.enable) begin
        paddle_q <= next_y;
        moving_q <= step_moving;
        if (!bus.ball_dir) begin
          state     <= ST_HOME;
          react_cnt <= '0;
        end else begin
          case (state)
            ST_HOME: begin
              state     <= ST_WAIT;
              react_cnt <= '0;
            end
            ST_WAIT: begin
              if (react_cnt == CNT_LAST) begin
                state     <= ST_TRACK;
                react_cnt <= '0;
              end else begin
                react_cnt <= react_cnt + CNT_W'(1);
              end
            end
            ST_TRACK: state <= ST_TRACK;
            default: begin
              state     <= ST_HOME;
              react_cnt <= '0;
            end
          endcase
        end
      end else begin
        // Frozen: hold position and state, but report no motion.
        moving_q <= 1'b0;
      end
    end
  end

`ifdef CPU_PADDLE_JITTER_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; offset latched from the pre-advance value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= 8'hA5;
      offset <= '0;
    end else if (tick_en) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (enter_track) begin
        offset <= $signed(CW'({1'b0, lfsr[4:0]})) - $signed(CW'(16));
      end
    end
  end
`else
  assign offset = '0;
  logic unused_enter_track;
  assign unused_enter_track = enter_track;
`endif

  assign bus.paddle_y = paddle_q;
  assign bus.moving   = moving_q;
  assign bus.ai_state = state;

endmodule

// File: tb/tb_cpu_paddle_ai.sv
`timescale 1ns/1ps
module tb_cpu_paddle_ai;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_paddle_ai_if #(.Y_W(10)) bus ();

  cpu_paddle_ai dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string tag;
    int    y;
    int    st;
    int    mv;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_y, m_st, m_cnt, m_mv;

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int m_step(input int d);
    int s;
    s = (8 * (d + 1)) / 4;
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int m_clamp(input int v);
    if (v < 0) return 0;
    if (v > 416) return 416;
    return v;
  endfunction

  task automatic model_reset();
    m_y = 208; m_st = 0; m_cnt = 0; m_mv = 0;
  endtask

  task automatic model_tick();
    int tgt, err, ae, d;
    if (!bus.enable) begin
      m_mv = 0;
      return;
    end
    if (m_st == 0)      tgt = 208;
    else if (m_st == 2) tgt = m_clamp(int'(bus.ball_y) - 32);
    else                tgt = m_y;
    err = tgt - m_y;
    ae  = (err < 0) ? -err : err;
    if (ae <= 2) begin
      m_mv = 0;
    end else begin
      d = (ae < m_step(int'(bus.difficulty))) ? ae : m_step(int'(bus.difficulty));
      m_y = m_clamp((err < 0) ? m_y - d : m_y + d);
      m_mv = 1;
    end
    if (!bus.ball_dir) begin
      m_st = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_cnt = 0;
    end else if (m_st == 1) begin
      if (m_cnt == 3) begin m_st = 2; m_cnt = 0; end
      else m_cnt++;
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".paddle_y"}, int'(bus.paddle_y), e.y);
    check({e.tag, ".ai_state"}, int'(bus.ai_state), e.st);
    check({e.tag, ".moving"},   int'(bus.moving),   e.mv);
  endtask

  task automatic do_tick(input string tag);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    model_tick();
    sb.push_back('{tag, m_y, m_st, m_mv});
    @(negedge clk);
    bus.frame_tick = 1'b0;
    compare_out();
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) do_tick(tag);
  endtask

  // Reset asserted together with frame_tick: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    model_reset();
    sb.push_back('{tag, m_y, m_st, m_mv});
    @(negedge clk);
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    compare_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    bus.ball_y     = 10'd0;
    bus.ball_dir   = 1'b0;
    bus.difficulty = 2'd3;
    model_reset();
    repeat (2) @(negedge clk);

    do_reset("reset");
    ticks(3, "idle");

    // Approach: 4 WAIT ticks, TRACK entered on tick 5 without moving
    bus.ball_dir = 1'b1; bus.ball_y = 10'd400; bus.difficulty = 2'd3;
    ticks(4, "react_wait");
    check("react_wait_state", int'(bus.ai_state), 1);
    do_tick("enter_track");
    check("enter_track_state", int'(bus.ai_state), 2);
    check("enter_track_y", int'(bus.paddle_y), 208);
    ticks(20, "chase");
    check("chase_end_y", int'(bus.paddle_y), 368);
    ticks(2, "chase_settled");
    check("chase_settled_mv", int'(bus.moving), 0);

    // Clamp at both playfield edges
    bus.ball_y = 10'd10;
    ticks(48, "clamp_top");
    check("clamp_top_y", int'(bus.paddle_y), 0);
    bus.ball_y = 10'd470;
    ticks(54, "clamp_bot");
    check("clamp_bot_y", int'(bus.paddle_y), 416);

    // Dead zone around paddle 208
    bus.ball_y = 10'd240;
    ticks(28, "to_208");
    bus.ball_y = 10'd242;
    do_tick("dz_err2");
    check("dz_err2_y", int'(bus.paddle_y), 208);
    bus.ball_y = 10'd243;
    do_tick("dz_err3");
    check("dz_err3_y", int'(bus.paddle_y), 211);

    // Difficulty change mid-chase
    bus.ball_y = 10'd240;
    do_tick("back_208");
    bus.ball_y = 10'd400; bus.difficulty = 2'd0;
    ticks(5, "diff0");
    check("diff0_y", int'(bus.paddle_y), 218);
    bus.difficulty = 2'd1;
    ticks(3, "diff1");
    check("diff1_y", int'(bus.paddle_y), 230);

    // Interrupt the reaction delay at count 2, then full delay again
    bus.ball_dir = 1'b0;
    do_tick("drop_track");
    bus.ball_dir = 1'b1;
    ticks(3, "wait_cnt2");
    bus.ball_dir = 1'b0;
    do_tick("wait_drop");
    check("wait_drop_state", int'(bus.ai_state), 0);
    bus.ball_dir = 1'b1;
    ticks(4, "rewait");
    check("rewait_state", int'(bus.ai_state), 1);
    do_tick("reenter_track");
    ticks(3, "retrack");

    // Freeze during TRACK; ball keeps moving underneath
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ball_y = 10'($urandom_range(0, 479));
      do_tick("freeze");
    end
    bus.enable = 1'b1;
    bus.ball_y = 10'd100;
    ticks(2, "unfreeze");

    // Reset while tracking
    do_reset("rst_track");
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_paddle_ai.md
Name: cpu_paddle_ai

Overview:
- Frame-rate, speed-limited computer opponent for the Pong datapath.
- Replaces instantaneous ball tracking with a three-state AI: return home, react after a delay, then chase the ball.
- Motion is limited by a difficulty-scaled step and a dead zone, and position is clamped to the playfield.
- Sits between the ball-physics block (ball_y, ball direction) and the paddle renderer/collision logic (paddle_y).

Parameters:
- Y_W, 10, width of all vertical coordinates
- SCREEN_H, 480, playfield height in pixels
- PADDLE_H, 64, paddle height in pixels; must be even
- HOME_Y, 208, rest/reset paddle top, (SCREEN_H-PADDLE_H)/2
- MAX_STEP, 8, max pixels moved per frame at difficulty 3
- DEADZONE, 2, |error| at or below this produces no motion
- REACT_FRAMES, 4, frame ticks spent in WAIT before tracking; must be ≥1

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous, active-high reset
- frame_tick, input, 1, one-cycle pulse per video frame; all updates occur only on it
- enable, input, 1, low freezes all state and the counter
- ball_y, input, Y_W, ball top coordinate
- ball_dir, input, 1, 1 = ball approaching the CPU side
- difficulty, input, 2, 0..3 speed level
- paddle_y, output, Y_W, paddle top coordinate (registered)
- moving, output, 1, 1 if paddle_y changed on the last frame_tick
- ai_state, output, 2, HOME=0, WAIT=1, TRACK=2

Behaviour:
- Reset (sync): paddle_y=HOME_Y, ai_state=HOME, moving=0, react counter=0.
- Update gating:
  - All registers change only on a clk edge where frame_tick=1 and enable=1.
  - With enable=0, everything holds, except moving, which clears on the next frame_tick.
  - rst has priority over frame_tick and enable.
- State transitions, evaluated on each qualifying tick:
  - Any state with ball_dir=0 → HOME; counter cleared.
  - HOME with ball_dir=1 → WAIT; counter=0.
  - WAIT with ball_dir=1: if counter==REACT_FRAMES-1 → TRACK, else counter+1.
  - TRACK with ball_dir=1 → stays TRACK.
- Target position:
  - HOME: target = HOME_Y.
  - WAIT: no motion; paddle holds.
  - TRACK: target = clamp(ball_y - PADDLE_H/2, 0, SCREEN_H-PADDLE_H).
  - Compute the target in signed Y_W+2 bits; no wrap for ball_y < PADDLE_H/2.
- Step size: step = max(1, (MAX_STEP*(difficulty+1))>>2). Defaults give 2, 4, 6, 8.
- Motion, where err = target - paddle_y (signed):
  - |err| ≤ DEADZONE: no move, moving=0.
  - Otherwise paddle_y += sign(err)*min(step,|err|), then clamp to [0, SCREEN_H-PADDLE_H]; moving=1.
  - The paddle never overshoots the target.
- Motion uses the state value before the transition.
  - Example: the tick that enters TRACK still uses WAIT behaviour, so the first move happens on the following tick.
  - Effective latency is REACT_FRAMES+1 ticks from the ball_dir rise to the first TRACK movement.
- ball_y and difficulty are sampled on the tick; they may change at any time.

Optional Feature:
- Macro: CPU_PADDLE_JITTER_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst) advances on every qualifying tick.
  - On the WAIT→TRACK transition it latches offset = {lfsr[4:0]} - 16 (signed, -16..15).
  - The offset is added to the TRACK target before the clamp, and held until the next WAIT→TRACK transition.
- When undefined: offset is 0; no LFSR logic is synthesised.

Decomposition:
- Shared pong_pkg holds:
  - ai_state encodings HOME/WAIT/TRACK
  - SCREEN_H/PADDLE_H defaults
  - the signed clamp function
- One natural sub-module: cpu_paddle_stepper, a combinational target/err/step/clamp datapath that returns next_y and moving.
- The FSM, react counter and LFSR stay in the top.

Test Plan:
- Reset → paddle_y=208, ai_state=0, moving=0; idle ticks with ball_dir=0 → paddle stays 208.
- ball_dir=1, ball_y=400, difficulty=3:
  - Ticks 1-4: ai_state WAIT, paddle 208.
  - Tick 5: TRACK, still 208.
  - Then +8 per tick, reaching 368 after 20 more ticks, then moving=0.
- Clamp: TRACK with ball_y=10 → paddle descends to 0, never negative; ball_y=470 → settles at 416.
- Dead zone: paddle 208 in TRACK.
  - ball_y=242 (err 2) → no move, moving=0.
  - ball_y=243 (err 3), difficulty=3 → paddle 211.
- Difficulty 0 from 208 toward target 368 → 2 px per tick; switching to difficulty 1 mid-chase → 4 px per tick from the next tick.
- Interrupts and freezes:
  - ball_dir drops during WAIT at count 2 → HOME, counter cleared; re-raise → full 4-tick wait again.
  - enable=0 for 10 ticks during TRACK → paddle_y and ai_state frozen.
  - rst during TRACK → 208/HOME next cycle.
